// File: rtl/multi_core_boot_sequencer.sv
// -----------------------------------------------------------------------------
// multi_core_boot_sequencer
//
// Purpose:
//   Boots an array of cores and then monitors their results.
//   Boot phase:
//     - streams the data image into data memory;
//     - sends every core its instruction image, register image,
//       barrier mask and start PC as network packets;
//     - ends with a single NULL packet.
//   Run phase:
//     - watches each core's store traffic for the sentinel addresses
//       (FAIL, DONE, PASS, CODE) and reports them on the status pins.
//
// Optional build macro:
//   BOOT_TIMEOUT_EN - enables a watchdog in RUN. Without it, timeout_o is 0.
//
// Ports:
//   clk, reset       clock; synchronous active-low reset
//   start_i          begin boot (only sampled in IDLE)
//   img_sel_o        image select (0 data, 1 instr, 2 reg)
//   img_addr_o       image read address
//   img_rdata_i      image word, valid one cycle after the address
//   pkt_*            network packet channel (valid/ready, id, op, data, addr)
//   mem_*            data-memory store channel (valid/ready, addr, wdata)
//   mon_valid_i      per-core store valid
//   mon_addr_i       per-core store address, packed 32 bits per core
//   mon_data_i       per-core store data, packed 32 bits per core
//   booted_o         boot complete
//   done_o           all cores reported DONE
//   fail_o           a FAIL event (or timeout) occurred
//   timeout_o        watchdog expired
//   fail_core_o      index of the failing core (NUM_CORES_P on timeout)
//   result_data_o    data of the latched DONE/FAIL event
//   code_valid_o     one-cycle pulse per CODE event
//   pass_count_o     saturating PASS event count
//   cycle_o          cycles since RUN was entered
//
// Packet opcodes: NULL=0, INSTR=1, REG=2, BAR=3, PC=4.
// -----------------------------------------------------------------------------
module multi_core_boot_sequencer #(
  parameter int          NUM_CORES_P      = 2,
  parameter int          DATA_DEPTH_P     = 1024,
  parameter int          INSTR_DEPTH_P    = 1024,
  parameter int          REG_DEPTH_P      = 64,
  parameter logic [31:0] BAR_MASK_P       = 32'h2,
  parameter logic [31:0] START_PC_P       = 32'h5,
  parameter int          TIMEOUT_CYCLES_P = 1000000,
  localparam int MAX01_LP  = (DATA_DEPTH_P > INSTR_DEPTH_P) ? DATA_DEPTH_P : INSTR_DEPTH_P,
  localparam int MAX012_LP = (MAX01_LP > REG_DEPTH_P) ? MAX01_LP : REG_DEPTH_P,
  localparam int MAX_DEPTH_LP = (MAX012_LP > 2) ? MAX012_LP : 2,
  localparam int ADDR_W_LP = $clog2(MAX_DEPTH_LP),
  localparam int FC_W_LP   = $clog2(NUM_CORES_P + 1),
  localparam int OP_W_LP   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  output logic [1:0]                 img_sel_o,
  output logic [ADDR_W_LP-1:0]       img_addr_o,
  input  logic [39:0]                img_rdata_i,
  output logic                       pkt_valid_o,
  input  logic                       pkt_ready_i,
  output logic [9:0]                 pkt_id_o,
  output logic [OP_W_LP-1:0]         pkt_op_o,
  output logic [31:0]                pkt_data_o,
  output logic [9:0]                 pkt_addr_o,
  output logic                       mem_valid_o,
  input  logic                       mem_ready_i,
  output logic [31:0]                mem_addr_o,
  output logic [31:0]                mem_wdata_o,
  input  logic [NUM_CORES_P-1:0]     mon_valid_i,
  input  logic [32*NUM_CORES_P-1:0]  mon_addr_i,
  input  logic [32*NUM_CORES_P-1:0]  mon_data_i,
  output logic                       booted_o,
  output logic                       done_o,
  output logic                       fail_o,
  output logic                       timeout_o,
  output logic [FC_W_LP-1:0]         fail_core_o,
  output logic [31:0]                result_data_o,
  output logic                       code_valid_o,
  output logic [15:0]                pass_count_o,
  output logic [31:0]                cycle_o
);

  localparam int CORE_W_LP = (NUM_CORES_P > 1) ? $clog2(NUM_CORES_P) : 1;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_DMEM  = 4'd1;
  localparam logic [3:0] S_INSTR = 4'd2;
  localparam logic [3:0] S_REG   = 4'd3;
  localparam logic [3:0] S_BAR   = 4'd4;
  localparam logic [3:0] S_PC    = 4'd5;
  localparam logic [3:0] S_NULLP = 4'd6;
  localparam logic [3:0] S_RUN   = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;
  localparam logic [3:0] S_FAIL  = 4'd9;

  // Per-element sub-phases of the image-driven states:
  //   PH_ADDR - the address is on img_addr_o and the ROM is sampling it;
  //   PH_CAP  - img_rdata_i holds the word and is captured into the payload;
  //   PH_SEND - valid is high and the payload is held until ready.
  localparam logic [1:0] PH_ADDR = 2'd0;
  localparam logic [1:0] PH_CAP  = 2'd1;
  localparam logic [1:0] PH_SEND = 2'd2;

  localparam logic [OP_W_LP-1:0] OP_NULL  = 3'd0;
  localparam logic [OP_W_LP-1:0] OP_INSTR = 3'd1;
  localparam logic [OP_W_LP-1:0] OP_REG   = 3'd2;
  localparam logic [OP_W_LP-1:0] OP_BAR   = 3'd3;
  localparam logic [OP_W_LP-1:0] OP_PC    = 3'd4;

  localparam logic [ADDR_W_LP-1:0] DATA_LAST_LP  = ADDR_W_LP'(DATA_DEPTH_P - 1);
  localparam logic [ADDR_W_LP-1:0] INSTR_LAST_LP = ADDR_W_LP'(INSTR_DEPTH_P - 1);
  localparam logic [ADDR_W_LP-1:0] REG_LAST_LP   = ADDR_W_LP'(REG_DEPTH_P - 1);
  localparam logic [CORE_W_LP-1:0] CORE_LAST_LP  = CORE_W_LP'(NUM_CORES_P - 1);

  localparam logic [31:0] ADDR_FAIL_LP = 32'hDEAD_DEAD;
  localparam logic [31:0] ADDR_DONE_LP = 32'h600D_BEEF;
  localparam logic [31:0] ADDR_PASS_LP = 32'hC0FF_EEEE;
  localparam logic [31:0] ADDR_CODE_LP = 32'hC0DE_C0DE;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic [3:0]             state_reg, state_next;
  logic [1:0]             phase_reg, phase_next;
  logic [ADDR_W_LP-1:0]   idx_reg, idx_next;
  logic [CORE_W_LP-1:0]   core_reg, core_next;
  logic [1:0]             img_sel_reg, img_sel_next;
  logic [ADDR_W_LP-1:0]   img_addr_reg, img_addr_next;
  logic                   pkt_valid_reg, pkt_valid_next;
  logic [9:0]             pkt_id_reg, pkt_id_next;
  logic [OP_W_LP-1:0]     pkt_op_reg, pkt_op_next;
  logic [31:0]            pkt_data_reg, pkt_data_next;
  logic [9:0]             pkt_addr_reg, pkt_addr_next;
  logic                   mem_valid_reg, mem_valid_next;
  logic [31:0]            mem_addr_reg, mem_addr_next;
  logic [31:0]            mem_wdata_reg, mem_wdata_next;
  logic                   booted_reg, booted_next;
  logic                   done_reg, done_next;
  logic                   fail_reg, fail_next;
  logic [FC_W_LP-1:0]     fail_core_reg, fail_core_next;
  logic [31:0]            result_reg, result_next;
  logic                   code_reg, code_next;
  logic [15:0]            pass_reg, pass_next;
  logic [31:0]            cycle_reg, cycle_next;
  logic [NUM_CORES_P-1:0] done_bits_reg, done_bits_next;
`ifdef BOOT_TIMEOUT_EN
  logic                   timeout_reg, timeout_next;
`endif

  // Bits [39:38] of the image word carry no field this block uses.
  logic unused_img_bits;
  assign unused_img_bits = ^img_rdata_i[39:38];

  // ---------------------------------------------------------------------------
  // Monitor decode, one slice per core
  // ---------------------------------------------------------------------------
  logic [NUM_CORES_P-1:0] hit_fail, hit_done, hit_pass, hit_code;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES_P; gi++) begin : g_mon
      logic [31:0] st_addr;
      assign st_addr      = mon_addr_i[gi*32 +: 32];
      assign hit_fail[gi] = mon_valid_i[gi] && (st_addr == ADDR_FAIL_LP);
      assign hit_done[gi] = mon_valid_i[gi] && (st_addr == ADDR_DONE_LP);
      assign hit_pass[gi] = mon_valid_i[gi] && (st_addr == ADDR_PASS_LP);
      assign hit_code[gi] = mon_valid_i[gi] && (st_addr == ADDR_CODE_LP);
    end
  endgenerate

  // Lowest-index priority: scanning downward lets the lowest hit overwrite.
  logic [FC_W_LP-1:0] fail_idx;
  logic [31:0]        fail_data;
  logic [31:0]        done_data;
  logic [FC_W_LP-1:0] pass_inc;
  logic [16:0]        pass_sum;
  logic [15:0]        pass_sat;

  always_comb begin
    fail_idx  = '0;
    fail_data = '0;
    done_data = '0;
    pass_inc  = '0;
    for (int c = NUM_CORES_P - 1; c >= 0; c--) begin
      if (hit_fail[c]) begin
        fail_idx  = FC_W_LP'(c);
        fail_data = mon_data_i[c*32 +: 32];
      end
      if (hit_done[c]) begin
        done_data = mon_data_i[c*32 +: 32];
      end
      pass_inc = pass_inc + FC_W_LP'(hit_pass[c]);
    end
    pass_sum = {1'b0, pass_reg} + 17'(pass_inc);
    pass_sat = pass_sum[16] ? 16'hFFFF : pass_sum[15:0];
  end

  // ---------------------------------------------------------------------------
  // Element bookkeeping for the image-driven states
  // ---------------------------------------------------------------------------
  logic elem_last;
  logic xfer_done;

  always_comb begin
    case (state_reg)
      S_DMEM:  elem_last = (idx_reg == DATA_LAST_LP);
      S_INSTR: elem_last = (idx_reg == INSTR_LAST_LP);
      default: elem_last = (idx_reg == REG_LAST_LP);
    endcase
    xfer_done = (state_reg == S_DMEM) ? mem_ready_i : pkt_ready_i;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    idx_next       = idx_reg;
    core_next      = core_reg;
    img_sel_next   = img_sel_reg;
    img_addr_next  = img_addr_reg;
    pkt_valid_next = pkt_valid_reg;
    pkt_id_next    = pkt_id_reg;
    pkt_op_next    = pkt_op_reg;
    pkt_data_next  = pkt_data_reg;
    pkt_addr_next  = pkt_addr_reg;
    mem_valid_next = mem_valid_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    booted_next    = booted_reg;
    done_next      = done_reg;
    fail_next      = fail_reg;
    fail_core_next = fail_core_reg;
    result_next    = result_reg;
    code_next      = 1'b0;
    pass_next      = pass_reg;
    cycle_next     = cycle_reg;
    done_bits_next = done_bits_reg;
`ifdef BOOT_TIMEOUT_EN
    timeout_next   = timeout_reg;
`endif

    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          state_next    = S_DMEM;
          phase_next    = PH_ADDR;
          idx_next      = '0;
          core_next     = '0;
          img_sel_next  = 2'd0;
          img_addr_next = '0;
        end
      end

      S_DMEM, S_INSTR, S_REG: begin
        case (phase_reg)
          PH_ADDR: phase_next = PH_CAP;
          PH_CAP: begin
            phase_next = PH_SEND;
            if (state_reg == S_DMEM) begin
              mem_valid_next = 1'b1;
              mem_addr_next  = {{(30 - ADDR_W_LP){1'b0}}, idx_reg, 2'b00};
              mem_wdata_next = img_rdata_i[31:0];
            end else if (state_reg == S_INSTR) begin
              pkt_valid_next = 1'b1;
              pkt_id_next    = 10'(core_reg) + 10'd1;
              pkt_op_next    = OP_INSTR;
              pkt_data_next  = {16'b0, img_rdata_i[15:0]};
              pkt_addr_next  = 10'(idx_reg);
            end else begin
              pkt_valid_next = 1'b1;
              pkt_id_next    = 10'(core_reg) + 10'd1;
              pkt_op_next    = OP_REG;
              pkt_data_next  = img_rdata_i[31:0];
              pkt_addr_next  = {4'b0, img_rdata_i[37:32]};
            end
          end
          default: begin
            if (xfer_done) begin
              mem_valid_next = 1'b0;
              pkt_valid_next = 1'b0;
              phase_next     = PH_ADDR;
              if (!elem_last) begin
                idx_next      = idx_reg + 1'b1;
                img_addr_next = idx_reg + 1'b1;
              end else begin
                idx_next      = '0;
                img_addr_next = '0;
                if (state_reg == S_DMEM) begin
                  state_next   = S_INSTR;
                  img_sel_next = 2'd1;
                end else if (state_reg == S_INSTR) begin
                  state_next   = S_REG;
                  img_sel_next = 2'd2;
                end else begin
                  // BAR carries a constant, so it goes straight to valid.
                  state_next     = S_BAR;
                  pkt_valid_next = 1'b1;
                  pkt_op_next    = OP_BAR;
                  pkt_data_next  = BAR_MASK_P;
                  pkt_addr_next  = 10'd24;
                end
              end
            end
          end
        endcase
      end

      S_BAR: begin
        if (pkt_ready_i) begin
          state_next    = S_PC;
          pkt_op_next   = OP_PC;
          pkt_data_next = START_PC_P;
          pkt_addr_next = 10'd0;
        end
      end

      S_PC: begin
        if (pkt_ready_i) begin
          if (core_reg == CORE_LAST_LP) begin
            state_next    = S_NULLP;
            pkt_id_next   = 10'd1;
            pkt_op_next   = OP_NULL;
            pkt_data_next = 32'hFFFF_FFFE;
            pkt_addr_next = 10'd24;
          end else begin
            state_next     = S_INSTR;
            core_next      = core_reg + 1'b1;
            pkt_valid_next = 1'b0;
            phase_next     = PH_ADDR;
            idx_next       = '0;
            img_sel_next   = 2'd1;
            img_addr_next  = '0;
          end
        end
      end

      S_NULLP: begin
        if (pkt_ready_i) begin
          state_next     = S_RUN;
          pkt_valid_next = 1'b0;
          booted_next    = 1'b1;
          cycle_next     = '0;
        end
      end

      S_RUN: begin
        cycle_next = cycle_reg + 32'd1;
        pass_next  = pass_sat;
        code_next  = |hit_code;
        if (|hit_fail) begin
          state_next     = S_FAIL;
          fail_next      = 1'b1;
          fail_core_next = fail_idx;
          result_next    = fail_data;
        end else begin
          if (|hit_done) begin
            result_next = done_data;
          end
          done_bits_next = done_bits_reg | hit_done;
          if (&(done_bits_reg | hit_done)) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end
`ifdef BOOT_TIMEOUT_EN
          else if (cycle_reg == 32'(TIMEOUT_CYCLES_P)) begin
            state_next     = S_FAIL;
            fail_next      = 1'b1;
            timeout_next   = 1'b1;
            fail_core_next = FC_W_LP'(NUM_CORES_P);
            result_next    = '0;
          end
`endif
        end
      end

      default: begin
        // DONE and FAIL hold until reset.
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      phase_reg     <= PH_ADDR;
      idx_reg       <= '0;
      core_reg      <= '0;
      img_sel_reg   <= '0;
      img_addr_reg  <= '0;
      pkt_valid_reg <= 1'b0;
      pkt_id_reg    <= '0;
      pkt_op_reg    <= '0;
      pkt_data_reg  <= '0;
      pkt_addr_reg  <= '0;
      mem_valid_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      booted_reg    <= 1'b0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
      fail_core_reg <= '0;
      result_reg    <= '0;
      code_reg      <= 1'b0;
      pass_reg      <= '0;
      cycle_reg     <= '0;
      done_bits_reg <= '0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      idx_reg       <= idx_next;
      core_reg      <= core_next;
      img_sel_reg   <= img_sel_next;
      img_addr_reg  <= img_addr_next;
      pkt_valid_reg <= pkt_valid_next;
      pkt_id_reg    <= pkt_id_next;
      pkt_op_reg    <= pkt_op_next;
      pkt_data_reg  <= pkt_data_next;
      pkt_addr_reg  <= pkt_addr_next;
      mem_valid_reg <= mem_valid_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      booted_reg    <= booted_next;
      done_reg      <= done_next;
      fail_reg      <= fail_next;
      fail_core_reg <= fail_core_next;
      result_reg    <= result_next;
      code_reg      <= code_next;
      pass_reg      <= pass_next;
      cycle_reg     <= cycle_next;
      done_bits_reg <= done_bits_next;
    end
  end

`ifdef BOOT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= timeout_next;
    end
  end
  assign timeout_o = timeout_reg;
`else
  assign timeout_o = 1'b0;
`endif

  assign img_sel_o     = img_sel_reg;
  assign img_addr_o    = img_addr_reg;
  assign pkt_valid_o   = pkt_valid_reg;
  assign pkt_id_o      = pkt_id_reg;
  assign pkt_op_o      = pkt_op_reg;
  assign pkt_data_o    = pkt_data_reg;
  assign pkt_addr_o    = pkt_addr_reg;
  assign mem_valid_o   = mem_valid_reg;
  assign mem_addr_o    = mem_addr_reg;
  assign mem_wdata_o   = mem_wdata_reg;
  assign booted_o      = booted_reg;
  assign done_o        = done_reg;
  assign fail_o        = fail_reg;
  assign fail_core_o   = fail_core_reg;
  assign result_data_o = result_reg;
  assign code_valid_o  = code_reg;
  assign pass_count_o  = pass_reg;
  assign cycle_o       = cycle_reg;

endmodule
